dram_audio_read_scheduler: RTL and testbench

//  Schedules 128-bit DRAM chunk reads for all instrument voices feeding the audio read FIFO/unstacker path.
//  A trigger starts a voice at addr_offsets[i]. The voice then reads consecutive chunks until addr_offsets[i+1],

---
 rtl/dram_audio_read_scheduler_pkg.sv | 31 +++
 rtl/dram_audio_read_scheduler_if.sv | 12 +
 rtl/dram_audio_read_scheduler_rr_arbiter.sv | 32 +++
 rtl/dram_audio_read_scheduler.sv | 134 +++++++++++++
 tb/tb_dram_audio_read_scheduler.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/dram_audio_read_scheduler_pkg.sv
// Shared audio DRAM definitions: address/period widths, read FIFO word layout and small helpers.
package dram_audio_read_scheduler_pkg;

    localparam int ADDR_W   = 24;
    localparam int PERIOD_W = 14;
    localparam int CHUNK_W  = 128;
    localparam int WORD_W   = 2 + PERIOD_W + ADDR_W + CHUNK_W;

    typedef logic [ADDR_W-1:0]   chunk_addr_t;
    typedef logic [PERIOD_W-1:0] period_t;

    // Returned FIFO word: the command tag comes back in the top bits next to the chunk address.
    typedef struct packed {
        logic [1:0]          pad;
        logic [PERIOD_W-1:0] period;
        logic [ADDR_W-1:0]   addr;
        logic [CHUNK_W-1:0]  data;
    } dram_audio_word_t;

    localparam int DATA_LSB   = 0;
    localparam int DATA_MSB   = CHUNK_W - 1;
    localparam int ADDR_LSB   = CHUNK_W;
    localparam int ADDR_MSB   = CHUNK_W + ADDR_W - 1;
    localparam int PERIOD_LSB = CHUNK_W + ADDR_W;
    localparam int PERIOD_MSB = CHUNK_W + ADDR_W + PERIOD_W - 1;

    function automatic chunk_addr_t next_chunk(input chunk_addr_t a);
        return a + 24'd1;
    endfunction

endpackage

// File: rtl/dram_audio_read_scheduler_if.sv
// Read-command channel towards the DRAM controller (valid/ready with address and period tag).
interface dram_audio_read_scheduler_if;
    import dram_audio_read_scheduler_pkg::*;

    logic        rd_cmd_valid;
    logic        rd_cmd_ready;
    chunk_addr_t rd_cmd_addr;
    period_t     rd_cmd_tag;

    modport master (output rd_cmd_valid, output rd_cmd_addr, output rd_cmd_tag, input rd_cmd_ready);
    modport slave  (input rd_cmd_valid, input rd_cmd_addr, input rd_cmd_tag, output rd_cmd_ready);
endinterface

// File: rtl/dram_audio_read_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: the first requester after last_grant (wrapping) wins when en is high.
module rr_arbiter #(
    parameter int N = 9,
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_grant,
    input  logic             en,
    output logic [N-1:0]     grant,
    output logic [IDX_W-1:0] grant_idx
);

    // Scan from last_grant+1 around to last_grant itself; only the first hit is taken.
    always_comb begin
        int   idx_s;
        logic hit_s;
        logic found_s;
        grant     = '0;
        grant_idx = '0;
        idx_s     = 0;
        hit_s     = 1'b0;
        found_s   = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx_s      = (int'(last_grant) + k) % N;
            hit_s      = en & ~found_s & req[idx_s];
            found_s    = found_s | hit_s;
            grant[idx_s] = grant[idx_s] | hit_s;
            grant_idx  = hit_s ? IDX_W'(idx_s) : grant_idx;
        end
    end

endmodule

// File: rtl/dram_audio_read_scheduler.sv
// Round-robin scheduler of chunk reads for all instrument voices, throttled by per-voice read-ahead credits.
module dram_audio_read_scheduler
    import dram_audio_read_scheduler_pkg::*;
#(
    parameter int INSTRUMENT_COUNT = 9,
    parameter int MAX_AHEAD        = 4
) (
    input  logic                                    clk,
    input  logic                                    rst_n,
    input  logic [INSTRUMENT_COUNT:0][ADDR_W-1:0]   addr_offsets,
    input  logic                                    addr_offsets_valid,
    input  logic [INSTRUMENT_COUNT-1:0]             trigger,
    input  logic [INSTRUMENT_COUNT-1:0]             chunk_consumed,
    input  logic                                    fifo_prog_full,
    input  logic [PERIOD_W-1:0]                     sample_period,
    dram_audio_read_scheduler_if.master             rd_cmd,
    output logic [INSTRUMENT_COUNT-1:0]             voice_active
);

    localparam int N     = INSTRUMENT_COUNT;
    localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
    localparam int CNT_W = $clog2(MAX_AHEAD + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_AHEAD);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [N-1:0]       eligible_s;
    logic [N-1:0]       grant_s;
    logic [IDX_W-1:0]   grant_idx_s;
    logic [ADDR_W-1:0]  voice_ptr_s [N];
    logic [ADDR_W-1:0]  grant_ptr_s;
    logic               slot_open_s;
    logic               issue_s;

    logic [IDX_W-1:0]   rr_r;
    logic               cmd_valid_r;
    logic [ADDR_W-1:0]  cmd_addr_r;
    logic [PERIOD_W-1:0] cmd_tag_r;

    assign slot_open_s = ~cmd_valid_r | rd_cmd.rd_cmd_ready;
    assign issue_s     = slot_open_s & (|eligible_s) & ~fifo_prog_full & addr_offsets_valid;

    rr_arbiter #(.N(N)) u_arb (
        .req        (eligible_s),
        .last_grant (rr_r),
        .en         (issue_s),
        .grant      (grant_s),
        .grant_idx  (grant_idx_s)
    );

    for (genvar i = 0; i < N; i++) begin : g_voice
        logic               active_r;
        logic [ADDR_W-1:0]  ptr_r;
        logic [CNT_W-1:0]   out_cnt_r;
        logic               start_s;
        logic               last_s;

        assign start_s = trigger[i] & addr_offsets_valid & (addr_offsets[i] < addr_offsets[i+1]);
        assign last_s  = (next_chunk(ptr_r) == addr_offsets[i+1]);
        assign eligible_s[i]  = active_r & (out_cnt_r < CNT_MAX) & (ptr_r < addr_offsets[i+1]);
        assign voice_ptr_s[i] = ptr_r;
        assign voice_active[i] = active_r;

        // Voice state; a trigger overrides a same-cycle grant's pointer advance but keeps the credit count.
        always_ff @(posedge clk) begin
            if (!rst_n) begin
                active_r  <= 1'b0;
                ptr_r     <= '0;
                out_cnt_r <= '0;
            end else begin
                if (start_s) begin
                    ptr_r <= addr_offsets[i];
                end else if (grant_s[i]) begin
                    ptr_r <= next_chunk(ptr_r);
                end else begin
                    ptr_r <= ptr_r;
                end

                if (!addr_offsets_valid) begin
                    active_r <= 1'b0;
                end else if (start_s) begin
                    active_r <= 1'b1;
                end else if (grant_s[i] && last_s) begin
                    active_r <= 1'b0;
                end else begin
                    active_r <= active_r;
                end

                case ({grant_s[i], chunk_consumed[i]})
                    2'b10:   out_cnt_r <= out_cnt_r + CNT_ONE;
                    2'b01:   out_cnt_r <= (out_cnt_r != '0) ? (out_cnt_r - CNT_ONE) : out_cnt_r;
                    default: out_cnt_r <= out_cnt_r;
                endcase
            end
        end
    end

    // One-hot grant selects the winning voice pointer without an indexed mux.
    always_comb begin
        grant_ptr_s = '0;
        for (int i = 0; i < N; i++) begin
            grant_ptr_s = grant_ptr_s | ({ADDR_W{grant_s[i]}} & voice_ptr_s[i]);
        end
    end

    // Command register: loads on issue, drops valid on acceptance, otherwise holds.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cmd_valid_r <= 1'b0;
            cmd_addr_r  <= '0;
            cmd_tag_r   <= '0;
            rr_r        <= '0;
        end else if (issue_s) begin
            cmd_valid_r <= 1'b1;
            cmd_addr_r  <= grant_ptr_s;
            cmd_tag_r   <= sample_period;
            rr_r        <= grant_idx_s;
        end else if (rd_cmd.rd_cmd_ready) begin
            cmd_valid_r <= 1'b0;
            cmd_addr_r  <= cmd_addr_r;
            cmd_tag_r   <= cmd_tag_r;
            rr_r        <= rr_r;
        end else begin
            cmd_valid_r <= cmd_valid_r;
            cmd_addr_r  <= cmd_addr_r;
            cmd_tag_r   <= cmd_tag_r;
            rr_r        <= rr_r;
        end
    end

    assign rd_cmd.rd_cmd_valid = cmd_valid_r;
    assign rd_cmd.rd_cmd_addr  = cmd_addr_r;
    assign rd_cmd.rd_cmd_tag   = cmd_tag_r;

endmodule

// File: tb/tb_dram_audio_read_scheduler.sv
// Bench for the audio read scheduler: two voices, a per-cycle reference model plus literal sequence checks.
module tb_dram_audio_read_scheduler;

    localparam int NV   = 2;
    localparam int MAXA = 4;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic [NV:0][23:0]    offs;
    logic                 ov;
    logic [NV-1:0]        trig;
    logic [NV-1:0]        cons;
    logic                 pf;
    logic [13:0]          period;
    logic                 ready;
    logic [NV-1:0]        voice_active;

    dram_audio_read_scheduler_if bus ();
    assign bus.rd_cmd_ready = ready;

    dram_audio_read_scheduler #(.INSTRUMENT_COUNT(NV), .MAX_AHEAD(MAXA)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .addr_offsets       (offs),
        .addr_offsets_valid (ov),
        .trigger            (trig),
        .chunk_consumed     (cons),
        .fifo_prog_full     (pf),
        .sample_period      (period),
        .rd_cmd             (bus),
        .voice_active       (voice_active)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    // Reference model state, plain integers
    bit m_valid = 1'b0;
    int m_addr  = 0;
    int m_tag   = 0;
    int m_last  = 0;
    bit m_act [NV];
    int m_ptr [NV];
    int m_cnt [NV];

    // Commands the DUT handed over (address, tag, voice_active at that moment)
    int acc_addr [$];
    int acc_tag  [$];
    int acc_act  [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_acc(input string name, input int k, input int exp_addr);
        check(name, (k < acc_addr.size()) ? 32'(acc_addr[k]) : 32'hFFFF_FFFF, 32'(exp_addr));
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic set_offs(input int a, input int b, input int c);
        offs[0] = 24'(a);
        offs[1] = 24'(b);
        offs[2] = 24'(c);
    endtask

    // Model: advance one clock from the rules of the scheduler
    always @(posedge clk) begin
        int  g;
        int  v;
        bit  issue;
        bit  gr;
        bit  st;
        if (!rst_n) begin
            m_valid = 1'b0; m_addr = 0; m_tag = 0; m_last = 0;
            for (int i = 0; i < NV; i++) begin
                m_act[i] = 1'b0; m_ptr[i] = 0; m_cnt[i] = 0;
            end
        end else begin
            g = -1;
            for (int k = 1; k <= NV; k++) begin
                v = (m_last + k) % NV;
                if (g < 0 && m_act[v] && m_cnt[v] < MAXA && m_ptr[v] < int'(offs[v+1])) g = v;
            end
            issue = (!m_valid || ready) && (g >= 0) && !pf && ov;
            if (issue) begin
                m_valid = 1'b1; m_addr = m_ptr[g]; m_tag = int'(period); m_last = g;
            end else if (ready) begin
                m_valid = 1'b0;
            end
            for (int i = 0; i < NV; i++) begin
                gr = issue && (g == i);
                st = trig[i] && ov && (offs[i] < offs[i+1]);
                m_cnt[i] = m_cnt[i] + int'(gr) - int'(cons[i]);
                if (m_cnt[i] < 0) m_cnt[i] = 0;
                if (!ov) m_act[i] = 1'b0;
                else if (st) m_act[i] = 1'b1;
                else if (gr && m_ptr[i] + 1 >= int'(offs[i+1])) m_act[i] = 1'b0;
                if (st) m_ptr[i] = int'(offs[i]);
                else if (gr) m_ptr[i] = m_ptr[i] + 1;
            end
        end
    end

    // Per-cycle compare against the model, plus capture of accepted commands
    always @(negedge clk) begin
        if (cmp_en) begin
            check("rd_cmd_valid", 32'(bus.rd_cmd_valid), 32'(m_valid));
            if (m_valid) begin
                check("rd_cmd_addr", 32'(bus.rd_cmd_addr), 32'(m_addr));
                check("rd_cmd_tag", 32'(bus.rd_cmd_tag), 32'(m_tag));
            end
            check("voice_active", 32'(voice_active), 32'({m_act[1], m_act[0]}));
            if (rst_n && bus.rd_cmd_valid && ready) begin
                acc_addr.push_back(int'(bus.rd_cmd_addr));
                acc_tag.push_back(int'(bus.rd_cmd_tag));
                acc_act.push_back(int'(voice_active));
            end
        end
    end

    initial begin
        rst_n = 1'b0; ready = 1'b1; pf = 1'b0; ov = 1'b1;
        trig = '0; cons = '0; period = 14'h1234;
        set_offs(0, 3, 5);
        step(2);
        cmp_en = 1'b1;
        check("reset_valid", 32'(bus.rd_cmd_valid), 32'd0);
        check("reset_addr", 32'(bus.rd_cmd_addr), 32'd0);
        check("reset_tag", 32'(bus.rd_cmd_tag), 32'd0);
        check("reset_active", 32'(voice_active), 32'd0);
        rst_n = 1'b1;

        // Single voice plays 0..2, then voice 1 plays 3..4
        trig = 2'b01; step(1); trig = '0; step(6);
        trig = 2'b10; step(1); trig = '0; step(5);
        check("t1_count", 32'(acc_addr.size()), 32'd5);
        chk_acc("t1_a0", 0, 0); chk_acc("t1_a1", 1, 1); chk_acc("t1_a2", 2, 2);
        chk_acc("t1_a3", 3, 3); chk_acc("t1_a4", 4, 4);
        check("t1_tag0", (acc_tag.size() > 0) ? 32'(acc_tag[0]) : 32'hFFFF_FFFF, 32'h1234);
        check("t1_act_a1", (acc_act.size() > 1) ? 32'(acc_act[1]) : 32'hFFFF_FFFF, 32'd1);
        check("t1_act_a2", (acc_act.size() > 2) ? 32'(acc_act[2]) : 32'hFFFF_FFFF, 32'd0);
        check("t1_act_a3", (acc_act.size() > 3) ? 32'(acc_act[3]) : 32'hFFFF_FFFF, 32'd2);
        cons = 2'b11; step(2); cons = 2'b01; step(1); cons = '0; step(1);
        acc_addr.delete(); acc_tag.delete(); acc_act.delete();

        // Two voices alternate, then stall on read-ahead credits
        period = 14'h0155;
        set_offs(0, 8, 16);
        trig = 2'b11; step(1); trig = '0; step(12);
        check("t2_count_stall", 32'(acc_addr.size()), 32'd8);
        chk_acc("t2_a0", 0, 0); chk_acc("t2_a1", 1, 8); chk_acc("t2_a2", 2, 1);
        chk_acc("t2_a3", 3, 9); chk_acc("t2_a6", 6, 3); chk_acc("t2_a7", 7, 11);
        check("t2_tag", (acc_tag.size() > 0) ? 32'(acc_tag[0]) : 32'hFFFF_FFFF, 32'h0155);
        cons = 2'b01; step(1); cons = '0; step(3);
        cons = 2'b10; step(1); cons = '0; step(3);
        check("t2_count_resume", 32'(acc_addr.size()), 32'd10);
        chk_acc("t2_a8", 8, 4); chk_acc("t2_a9", 9, 12);

        // Back-pressure: pending command held while ready is low
        ready = 1'b0;
        cons = 2'b01; step(1); cons = '0; step(6);
        check("t3_held_valid", 32'(bus.rd_cmd_valid), 32'd1);
        check("t3_held_addr", 32'(bus.rd_cmd_addr), 32'd5);
        check("t3_no_accept", 32'(acc_addr.size()), 32'd10);
        ready = 1'b1; step(3);
        check("t3_accept_once", 32'(acc_addr.size()), 32'd11);
        chk_acc("t3_a10", 10, 5);

        // FIFO near full blocks new grants; release resumes at the next rr voice
        pf = 1'b1;
        cons = 2'b11; step(1); cons = '0; step(4);
        check("t4_blocked_valid", 32'(bus.rd_cmd_valid), 32'd0);
        check("t4_blocked_count", 32'(acc_addr.size()), 32'd11);
        pf = 1'b0; step(4);
        check("t4_count", 32'(acc_addr.size()), 32'd13);
        chk_acc("t4_a11", 11, 13); chk_acc("t4_a12", 12, 6);

        // Mid-run reset, then retrigger in the cycle voice 0 is granted addr 2
        rst_n = 1'b0; step(1);
        check("t5_rst_valid", 32'(bus.rd_cmd_valid), 32'd0);
        check("t5_rst_active", 32'(voice_active), 32'd0);
        rst_n = 1'b1;
        acc_addr.delete(); acc_tag.delete(); acc_act.delete();
        trig = 2'b01; step(1); trig = '0; step(2);
        trig = 2'b01; step(1); trig = '0; step(6);
        check("t5_count", 32'(acc_addr.size()), 32'd4);
        chk_acc("t5_a2", 2, 2); chk_acc("t5_a3", 3, 0);
        check("t5_active", 32'(voice_active), 32'd1);

        // Ignored triggers, offsets-invalid clearing, reset with a pending command
        rst_n = 1'b0; step(1); rst_n = 1'b1;
        acc_addr.delete(); acc_tag.delete(); acc_act.delete();
        ov = 1'b0; trig = 2'b01; step(1); trig = '0; step(3);
        check("t6_invalid_offs", 32'(voice_active), 32'd0);
        ov = 1'b1; set_offs(0, 8, 8);
        trig = 2'b10; step(1); trig = '0; step(3);
        check("t6_empty_voice", 32'(voice_active), 32'd0);
        check("t6_no_cmds", 32'(acc_addr.size()), 32'd0);
        set_offs(0, 8, 16); ready = 1'b0;
        trig = 2'b01; step(1); trig = '0; step(2);
        ov = 1'b0; step(1);
        check("t6_ov_clear", 32'(voice_active), 32'd0);
        check("t6_pending_kept", 32'(bus.rd_cmd_valid), 32'd1);
        check("t6_pending_addr", 32'(bus.rd_cmd_addr), 32'd0);
        step(2);
        rst_n = 1'b0; step(1);
        check("t6_rst_pending", 32'(bus.rd_cmd_valid), 32'd0);
        rst_n = 1'b1; ov = 1'b1; ready = 1'b1; step(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
